// File: rtl/pipereg_elastic.sv
// pipereg_elastic: DEPTH-stage pipeline register carrying payload + control,
// with a per-stage valid bit, hazard stall, per-stage flush and optional
// bubble collapsing while stalled.
module pipereg_elastic #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned CTRL_W     = 8,
    parameter int unsigned DEPTH      = 2,
    parameter bit          COLLAPSE   = 1'b0,
    parameter bit          CLEAR_DATA = 1'b0
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            in_data,
    input  logic [CTRL_W-1:0]            in_ctrl,
    output logic                         in_ready,
    input  logic                         stall,
    input  logic [DEPTH-1:0]             flush,
    output logic                         out_valid,
    output logic [DATA_W-1:0]            out_data,
    output logic [CTRL_W-1:0]            out_ctrl,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int unsigned LAST  = DEPTH - 1;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]  v_q;
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [CTRL_W-1:0] ctrl_q [DEPTH];

    logic [DEPTH-1:0]  adv;
    logic [DEPTH-1:0]  src_v;
    logic [DATA_W-1:0] src_data [DEPTH];
    logic [CTRL_W-1:0] src_ctrl [DEPTH];

    // Advance enables, walking from the last stage back to stage 0.
    // The recursive adv[k] = adv[k+1] || !v[k] is flattened into a running
    // "bubble at or below k" flag so the enable vector has no self-loop.
    always_comb begin
        logic bubble_seen;
        bubble_seen = 1'b0;
        adv         = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            bubble_seen    = bubble_seen | ~v_q[LAST-i];
            adv[LAST-i]    = ~stall | (COLLAPSE & bubble_seen);
        end
    end

    // Source of each stage: the inputs for stage 0, the previous stage otherwise.
    always_comb begin
        src_v[0]    = in_valid;
        src_data[0] = in_data;
        src_ctrl[0] = in_ctrl;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            src_v[k]    = v_q[k-1];
            src_data[k] = data_q[k-1];
            src_ctrl[k] = ctrl_q[k-1];
        end
    end

    // Stage registers: reset > flush > advance > hold; ctrl is zero in any bubble.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            v_q <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
                ctrl_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if (flush[k]) begin
                    v_q[k]    <= 1'b0;
                    ctrl_q[k] <= '0;
                    if (CLEAR_DATA) begin
                        data_q[k] <= '0;
                    end
                end else if (adv[k]) begin
                    v_q[k]    <= src_v[k];
                    ctrl_q[k] <= src_v[k] ? src_ctrl[k] : '0;
                    data_q[k] <= src_data[k];
                end
            end
        end
    end

    // Occupancy is the popcount of the stage valid bits.
    always_comb begin
        occupancy = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            occupancy = occupancy + OCC_W'(v_q[k]);
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = v_q[LAST];
    assign out_data  = data_q[LAST];
    assign out_ctrl  = ctrl_q[LAST];

endmodule

// File: tb/tb_pipereg_elastic.sv
// Directed bench for pipereg_elastic: two instances share all inputs,
// u_dut0 (COLLAPSE=0, CLEAR_DATA=0) and u_dut1 (COLLAPSE=1, CLEAR_DATA=1).
module tb_pipereg_elastic;

    logic        clk;
    logic        nrst;
    logic        in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ctrl;
    logic        stall;
    logic [2:0]  flush;

    logic        in_ready0, in_ready1;
    logic        out_valid0, out_valid1;
    logic [31:0] out_data0, out_data1;
    logic [3:0]  out_ctrl0, out_ctrl1;
    logic [1:0]  occ0, occ1;

    int errors = 0;
    int checks = 0;

    pipereg_elastic #(.DATA_W(32), .CTRL_W(4), .DEPTH(3), .COLLAPSE(1'b0), .CLEAR_DATA(1'b0)) u_dut0 (
        .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_data(in_data), .in_ctrl(in_ctrl),
        .in_ready(in_ready0), .stall(stall), .flush(flush), .out_valid(out_valid0),
        .out_data(out_data0), .out_ctrl(out_ctrl0), .occupancy(occ0)
    );

    pipereg_elastic #(.DATA_W(32), .CTRL_W(4), .DEPTH(3), .COLLAPSE(1'b1), .CLEAR_DATA(1'b1)) u_dut1 (
        .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_data(in_data), .in_ctrl(in_ctrl),
        .in_ready(in_ready1), .stall(stall), .flush(flush), .out_valid(out_valid1),
        .out_data(out_data1), .out_ctrl(out_ctrl1), .occupancy(occ1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] c);
        in_valid = v;
        in_data  = d;
        in_ctrl  = c;
    endtask

    // Output triple of one instance against expected values.
    task automatic chk_out(input string tag, input int dut, input logic v,
                           input logic [31:0] d, input logic [3:0] c);
        if (dut == 0) begin
            check({tag, ".d0.valid"}, 32'(out_valid0), 32'(v));
            check({tag, ".d0.data"},  out_data0,       d);
            check({tag, ".d0.ctrl"},  32'(out_ctrl0),  32'(c));
        end else begin
            check({tag, ".d1.valid"}, 32'(out_valid1), 32'(v));
            check({tag, ".d1.data"},  out_data1,       d);
            check({tag, ".d1.ctrl"},  32'(out_ctrl1),  32'(c));
        end
    endtask

    // Fill the pipe with base, base+1, base+2 (ctrl F), no stall, no flush.
    task automatic feed3(input logic [31:0] base);
        nrst  = 1'b1;
        stall = 1'b0;
        flush = 3'b000;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, base + 32'(i), 4'hF);
            tick();
        end
    endtask

    initial begin
        // 1. reset with a live input
        nrst = 1'b0; stall = 1'b0; flush = 3'b000;
        drive(1'b1, 32'hFFFF_FFFF, 4'hF);
        tick(); tick();
        chk_out("rst", 0, 1'b0, 32'h0, 4'h0);
        chk_out("rst", 1, 1'b0, 32'h0, 4'h0);
        check("rst.occ0", 32'(occ0), 32'd0);
        check("rst.occ1", 32'(occ1), 32'd0);
        check("rst.rdy0", 32'(in_ready0), 32'd1);
        check("rst.rdy1", 32'(in_ready1), 32'd1);

        // 2. back-to-back stream A0..A4, 3-cycle latency
        nrst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i < 5) drive(1'b1, 32'hA0 + 32'(i), 4'hF);
            else       drive(1'b0, 32'h0, 4'h0);
            tick();
            if (i >= 2 && i <= 6) begin
                chk_out("stream", 0, 1'b1, 32'hA0 + 32'(i - 2), 4'hF);
                chk_out("stream", 1, 1'b1, 32'hA0 + 32'(i - 2), 4'hF);
            end else begin
                chk_out("stream_idle", 0, 1'b0, 32'h0, 4'h0);
                chk_out("stream_idle", 1, 1'b0, 32'h0, 4'h0);
            end
        end

        // 3/4. stages {A0, bubble(B0), A1}, then stall with A2 offered
        drive(1'b1, 32'hA0, 4'hF); tick();
        drive(1'b0, 32'hB0, 4'hF); tick();
        drive(1'b1, 32'hA1, 4'hF); tick();
        check("gap.occ0", 32'(occ0), 32'd2);
        check("gap.occ1", 32'(occ1), 32'd2);
        stall = 1'b1;
        drive(1'b1, 32'hA2, 4'h5);
        #1;
        check("stall1.rdy0", 32'(in_ready0), 32'd0);
        check("stall1.rdy1", 32'(in_ready1), 32'd1);
        tick();
        check("stall1.occ0", 32'(occ0), 32'd2);
        check("stall1.occ1", 32'(occ1), 32'd3);
        chk_out("stall1", 0, 1'b1, 32'hA0, 4'hF);
        chk_out("stall1", 1, 1'b1, 32'hA0, 4'hF);
        check("stall2.rdy0", 32'(in_ready0), 32'd0);
        check("stall2.rdy1", 32'(in_ready1), 32'd0);
        tick();
        check("stall2.occ0", 32'(occ0), 32'd2);
        check("stall2.occ1", 32'(occ1), 32'd3);
        stall = 1'b0;
        drive(1'b0, 32'h0, 4'h0);
        tick();
        chk_out("drainA.1", 0, 1'b0, 32'hB0, 4'h0);
        chk_out("drainA.1", 1, 1'b1, 32'hA1, 4'hF);
        tick();
        chk_out("drainA.2", 0, 1'b1, 32'hA1, 4'hF);
        chk_out("drainA.2", 1, 1'b1, 32'hA2, 4'h5);
        tick();
        chk_out("drainA.3", 0, 1'b0, 32'h0, 4'h0);
        chk_out("drainA.3", 1, 1'b0, 32'h0, 4'h0);

        // 5a. flush middle stage of a full, moving pipe
        feed3(32'hA0);
        check("full.occ0", 32'(occ0), 32'd3);
        check("full.occ1", 32'(occ1), 32'd3);
        flush = 3'b010;
        drive(1'b1, 32'hC0, 4'hF);
        tick();
        chk_out("flushmv", 0, 1'b1, 32'hA1, 4'hF);
        chk_out("flushmv", 1, 1'b1, 32'hA1, 4'hF);
        check("flushmv.occ0", 32'(occ0), 32'd2);
        check("flushmv.occ1", 32'(occ1), 32'd2);
        flush = 3'b000;
        drive(1'b0, 32'h0, 4'h0);
        tick();
        chk_out("flushmv.k", 0, 1'b0, 32'hA1, 4'h0);
        chk_out("flushmv.k", 1, 1'b0, 32'h0, 4'h0);
        tick();
        chk_out("flushmv.n", 0, 1'b1, 32'hC0, 4'hF);
        chk_out("flushmv.n", 1, 1'b1, 32'hC0, 4'hF);
        tick();
        chk_out("flushmv.e", 0, 1'b0, 32'h0, 4'h0);
        chk_out("flushmv.e", 1, 1'b0, 32'h0, 4'h0);

        // 5b. flush middle stage of a full, stalled pipe
        feed3(32'hA0);
        stall = 1'b1;
        flush = 3'b010;
        drive(1'b1, 32'hD0, 4'hF);
        #1;
        check("flushst.rdy0", 32'(in_ready0), 32'd0);
        check("flushst.rdy1", 32'(in_ready1), 32'd0);
        tick();
        check("flushst.occ0", 32'(occ0), 32'd2);
        check("flushst.occ1", 32'(occ1), 32'd2);
        chk_out("flushst", 0, 1'b1, 32'hA0, 4'hF);
        chk_out("flushst", 1, 1'b1, 32'hA0, 4'hF);
        stall = 1'b0;
        flush = 3'b000;
        drive(1'b0, 32'h0, 4'h0);
        tick();
        chk_out("flushst.k", 0, 1'b0, 32'hA1, 4'h0);
        chk_out("flushst.k", 1, 1'b0, 32'h0, 4'h0);
        tick();
        chk_out("flushst.h", 0, 1'b1, 32'hA2, 4'hF);
        chk_out("flushst.h", 1, 1'b1, 32'hA2, 4'hF);

        // 6. reset together with a full flush on a stalled full pipe
        feed3(32'hE0);
        stall = 1'b1;
        flush = 3'b111;
        nrst  = 1'b0;
        drive(1'b1, 32'hFFFF_FFFF, 4'hF);
        tick();
        chk_out("rstfl", 0, 1'b0, 32'h0, 4'h0);
        chk_out("rstfl", 1, 1'b0, 32'h0, 4'h0);
        check("rstfl.occ0", 32'(occ0), 32'd0);
        check("rstfl.occ1", 32'(occ1), 32'd0);

        // flush alone on a full stalled pipe
        feed3(32'hE0);
        stall = 1'b1;
        flush = 3'b111;
        drive(1'b0, 32'h0, 4'h0);
        tick();
        check("flall.occ0", 32'(occ0), 32'd0);
        check("flall.occ1", 32'(occ1), 32'd0);
        chk_out("flall", 0, 1'b0, 32'hE0, 4'h0);
        chk_out("flall", 1, 1'b0, 32'h0, 4'h0);
        flush = 3'b000;
        #1;
        check("flall.rdy0", 32'(in_ready0), 32'd0);
        check("flall.rdy1", 32'(in_ready1), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
